matmul_skew_feeder: RTL and testbench

// - Parametrised successor to the systolic-array operand skewer. Streams A rows and B columns
//   as diagonally skewed lane vectors into an output-stationary MAX_DIM x MAX_DIM MAC array.
// - Adds a valid/ready backpressure handshake, abort, pre-transposed-B mode and a sized drain.
// - Sits between the operand register file and the systolic array.
// - done_o tells the control FSM the array holds final C results.

---
 rtl/matmul_skew_feeder_pkg.sv | 25 ++
 rtl/matmul_lane_select.sv | 45 ++++
 rtl/matmul_skew_feeder.sv | 174 +++++++++++++++++
 tb/tb_matmul_skew_feeder.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_skew_feeder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : matmul_skew_feeder_pkg
//  Description : Shared definitions for the systolic-array operand skewer:
//                FSM state encodings and the flat matrix element index helper
//                used by the feeder, the array and the C-masking blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package matmul_skew_feeder_pkg;

  // Controller state encodings (2-bit, explicit width).
  localparam int         STATE_W  = 2;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FEED  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // LSB position of element (row, col) in a row-major flat matrix vector.
  function automatic int elem_lsb(input int row, input int col,
                                  input int max_dim, input int data_width);
    return (row * max_dim + col) * data_width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/matmul_lane_select.sv
`default_nettype none
// ============================================================================
//  Module      : matmul_lane_select
//  Description : Combinational skew pick for one operand. For every lane i the
//                element row i, column (t - i) is presented when the lane is
//                below the active limit and the column falls inside 0..K-1;
//                otherwise the lane carries zero. Rows of the flat matrix are
//                the lanes, so B must be supplied already transposed.
//  Revision    : 1.0 - initial release
// ============================================================================
module matmul_lane_select
  import matmul_skew_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_DIM    = 4,
  parameter int DIM_W      = 2,
  parameter int CNT_W      = 5
) (
  input  logic [MAX_DIM*MAX_DIM*DATA_WIDTH-1:0] matrix,
  input  logic [CNT_W-1:0]                      beat,
  input  logic [CNT_W-1:0]                      limit,
  input  logic [CNT_W-1:0]                      k_dim,
  output logic [MAX_DIM*DATA_WIDTH-1:0]         lanes
);

  for (genvar i = 0; i < MAX_DIM; i++) begin : g_lane
    localparam logic [CNT_W-1:0] LANE = CNT_W'(i);

    logic [CNT_W-1:0] offs;
    logic [DIM_W-1:0] col;
    logic             hit;

    // Column index into this lane's row; only meaningful when hit is set,
    // and then offs < K <= MAX_DIM so the low DIM_W bits are exact.
    assign offs = beat - LANE;
    assign col  = offs[DIM_W-1:0];
    assign hit  = (LANE < limit) && (beat >= LANE) && (offs < k_dim);

    assign lanes[i*DATA_WIDTH +: DATA_WIDTH] =
      hit ? matrix[elem_lsb(i, int'(col), MAX_DIM, DATA_WIDTH) +: DATA_WIDTH]
          : '0;
  end

endmodule
`default_nettype wire

// File: rtl/matmul_skew_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : matmul_skew_feeder
//  Description : Streams A rows and B columns as diagonally skewed lane
//                vectors into an output-stationary MAX_DIM x MAX_DIM MAC
//                array, with valid/ready backpressure, abort, optional
//                pre-transposed B and a sized zero drain (FLUSH).
//  Revision    : 1.0 - initial release
// ============================================================================
module matmul_skew_feeder
  import matmul_skew_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BUS_WIDTH  = 32,
  parameter int DIM_W      = 2,
  parameter int CNT_W      = 5
) (
  input  logic                                                       clk_i,
  input  logic                                                       rst_i,
  input  logic                                                       start_i,
  input  logic                                                       abort_i,
  input  logic                                                       b_transposed_i,
  input  logic [(BUS_WIDTH/DATA_WIDTH)*(BUS_WIDTH/DATA_WIDTH)*DATA_WIDTH-1:0] matrix_a_i,
  input  logic [(BUS_WIDTH/DATA_WIDTH)*(BUS_WIDTH/DATA_WIDTH)*DATA_WIDTH-1:0] matrix_b_i,
  input  logic [DIM_W-1:0]                                           n_i,
  input  logic [DIM_W-1:0]                                           k_i,
  input  logic [DIM_W-1:0]                                           m_i,
  input  logic                                                       out_ready_i,
  output logic                                                       out_valid_o,
  output logic [(BUS_WIDTH/DATA_WIDTH)*DATA_WIDTH-1:0]               out_vec_a_o,
  output logic [(BUS_WIDTH/DATA_WIDTH)*DATA_WIDTH-1:0]               out_vec_b_o,
  output logic                                                       busy_o,
  output logic                                                       done_o
);

  localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
  localparam int MAT_W   = MAX_DIM * MAX_DIM * DATA_WIDTH;
  localparam int VEC_W   = MAX_DIM * DATA_WIDTH;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);
  localparam logic [CNT_W-DIM_W-1:0] DIM_PAD = '0;

  logic [STATE_W-1:0] state;
  logic [CNT_W-1:0]   beat;
  logic [CNT_W-1:0]   n_dim;
  logic [CNT_W-1:0]   k_dim;
  logic [CNT_W-1:0]   m_dim;
  logic [MAT_W-1:0]   a_mat;
  logic [MAT_W-1:0]   b_mat;

  logic [MAT_W-1:0]   b_in_t;
  logic [CNT_W-1:0]   max_nm;
  logic [CNT_W-1:0]   feed_last;
  logic [CNT_W-1:0]   flush_last;
  logic               accept;
  logic [VEC_W-1:0]   sel_a;
  logic [VEC_W-1:0]   sel_b;

  // B is held internally as B^T so both operands share the row-per-lane pick.
  for (genvar r = 0; r < MAX_DIM; r++) begin : g_tr_row
    for (genvar c = 0; c < MAX_DIM; c++) begin : g_tr_col
      assign b_in_t[elem_lsb(r, c, MAX_DIM, DATA_WIDTH) +: DATA_WIDTH] =
        matrix_b_i[elem_lsb(c, r, MAX_DIM, DATA_WIDTH) +: DATA_WIDTH];
    end
  end

  // Beat limits: K+max(N,M)-1 feed beats and N+M-1 flush beats. Dims are
  // at least 1, so neither subtraction can wrap.
  assign max_nm     = (n_dim > m_dim) ? n_dim : m_dim;
  assign feed_last  = k_dim + max_nm - CNT_TWO;
  assign flush_last = n_dim + m_dim - CNT_TWO;

  assign out_valid_o = (state == ST_FEED) || (state == ST_FLUSH);
  assign busy_o      = out_valid_o;
  assign done_o      = (state == ST_DONE);
  assign accept      = out_valid_o && out_ready_i;

  matmul_lane_select #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_DIM    (MAX_DIM),
    .DIM_W      (DIM_W),
    .CNT_W      (CNT_W)
  ) u_sel_a (
    .matrix (a_mat),
    .beat   (beat),
    .limit  (n_dim),
    .k_dim  (k_dim),
    .lanes  (sel_a)
  );

  matmul_lane_select #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_DIM    (MAX_DIM),
    .DIM_W      (DIM_W),
    .CNT_W      (CNT_W)
  ) u_sel_b (
    .matrix (b_mat),
    .beat   (beat),
    .limit  (m_dim),
    .k_dim  (k_dim),
    .lanes  (sel_b)
  );

  // Lane data is shown only during FEED; FLUSH and idle states drive zeros.
  assign out_vec_a_o = (state == ST_FEED) ? sel_a : '0;
  assign out_vec_b_o = (state == ST_FEED) ? sel_b : '0;

  // Controller: operand/dim latch on start, beat advance on handshake,
  // abort overrides the handshake, reset overrides everything.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      beat  <= '0;
      n_dim <= '0;
      k_dim <= '0;
      m_dim <= '0;
      a_mat <= '0;
      b_mat <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            state <= ST_FEED;
            beat  <= '0;
            a_mat <= matrix_a_i;
            b_mat <= b_transposed_i ? matrix_b_i : b_in_t;
            n_dim <= {DIM_PAD, n_i} + CNT_ONE;
            k_dim <= {DIM_PAD, k_i} + CNT_ONE;
            m_dim <= {DIM_PAD, m_i} + CNT_ONE;
          end
        end
        ST_FEED: begin
          if (abort_i) begin
            state <= ST_IDLE;
            beat  <= '0;
          end else if (accept) begin
            if (beat == feed_last) begin
              state <= ST_FLUSH;
              beat  <= '0;
            end else begin
              beat <= beat + CNT_ONE;
            end
          end
        end
        ST_FLUSH: begin
          if (abort_i) begin
            state <= ST_IDLE;
            beat  <= '0;
          end else if (accept) begin
            if (beat == flush_last) begin
              state <= ST_DONE;
              beat  <= '0;
            end else begin
              beat <= beat + CNT_ONE;
            end
          end
        end
        ST_DONE: begin
          // Leaving only on a low start level prevents a held start retrigger.
          if (abort_i || !start_i) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          beat  <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_matmul_skew_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_matmul_skew_feeder
//  Description : Scoreboard bench for matmul_skew_feeder. Expected beats come
//                from a reference model built directly on matrix arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_matmul_skew_feeder;

  localparam int DW    = 8;
  localparam int MD    = 4;
  localparam int MAT_W = MD * MD * DW;
  localparam int VEC_W = MD * DW;

  typedef struct packed {
    logic [VEC_W-1:0] a;
    logic [VEC_W-1:0] b;
  } beat_t;

  logic             clk   = 1'b0;
  logic             rst   = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             bt    = 1'b0;
  logic             ready = 1'b0;
  logic [MAT_W-1:0] mat_a = '0;
  logic [MAT_W-1:0] mat_b = '0;
  logic [1:0]       n = '0, k = '0, m = '0;
  logic             out_valid, busy, done;
  logic [VEC_W-1:0] vec_a, vec_b;

  int    vectors     = 0;
  int    miscompares = 0;
  int    accepted    = 0;
  int    ready_mode  = 0;
  beat_t exp_q[$];
  logic [7:0] ma [MD][MD];
  logic [7:0] mb [MD][MD];

  matmul_skew_feeder #(
    .DATA_WIDTH (8),
    .BUS_WIDTH  (32),
    .DIM_W      (2),
    .CNT_W      (5)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .abort_i        (abort),
    .b_transposed_i (bt),
    .matrix_a_i     (mat_a),
    .matrix_b_i     (mat_b),
    .n_i            (n),
    .k_i            (k),
    .m_i            (m),
    .out_ready_i    (ready),
    .out_valid_o    (out_valid),
    .out_vec_a_o    (vec_a),
    .out_vec_b_o    (vec_b),
    .busy_o         (busy),
    .done_o         (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ready pattern generator: 0 always-ready, 1 pattern 1,0,0, 2 random, else 0.
  initial begin
    int c;
    c = 0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       ready = 1'b1;
        1:       ready = ((c % 3) == 0);
        2:       ready = 1'($urandom_range(0, 1));
        default: ready = 1'b0;
      endcase
      c++;
    end
  end

  // Monitor: pops on each accepted beat, checks stall stability.
  initial begin
    beat_t e;
    beat_t held;
    bit    stalled;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (out_valid && stalled)
          check("stall_hold", {vec_a, vec_b}, held);
        if (out_valid && ready && !abort) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_beat: got %h expected no beat", {vec_a, vec_b});
          end else begin
            e = exp_q.pop_front();
            check("beat", {vec_a, vec_b}, e);
          end
          accepted++;
          stalled = 1'b0;
        end else if (out_valid) begin
          stalled = 1'b1;
          held    = {vec_a, vec_b};
        end else begin
          stalled = 1'b0;
        end
      end
    end
  end

  // Reference model: lane i of A = A[i][t-i], lane j of B = B[t-j][j].
  task automatic expect_run(input int nn, input int kk, input int mm);
    beat_t e;
    int    mx;
    mx = (nn > mm) ? nn : mm;
    for (int t = 0; t < kk + mx - 1; t++) begin
      e = '0;
      for (int i = 0; i < MD; i++)
        if (i < nn && t - i >= 0 && t - i < kk) e.a[i*DW +: DW] = ma[i][t-i];
      for (int j = 0; j < MD; j++)
        if (j < mm && t - j >= 0 && t - j < kk) e.b[j*DW +: DW] = mb[t-j][j];
      exp_q.push_back(e);
    end
    for (int t = 0; t < nn + mm - 1; t++) exp_q.push_back('0);
  endtask

  task automatic fill_random();
    for (int r = 0; r < MD; r++)
      for (int c = 0; c < MD; c++) begin
        ma[r][c] = 8'($urandom_range(1, 255));
        mb[r][c] = 8'($urandom_range(1, 255));
      end
  endtask

  task automatic load(input int nn, input int kk, input int mm, input bit trans);
    n  = 2'(nn - 1);
    k  = 2'(kk - 1);
    m  = 2'(mm - 1);
    bt = trans;
    for (int r = 0; r < MD; r++)
      for (int c = 0; c < MD; c++) begin
        mat_a[(r*MD+c)*DW +: DW] = ma[r][c];
        mat_b[(r*MD+c)*DW +: DW] = trans ? mb[c][r] : mb[r][c];
      end
  endtask

  task automatic wait_done(input string name);
    int i;
    for (i = 0; i < 400 && !done; i++) tick();
    check({name, "_done"}, 64'(done), 64'd1);
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  // One complete run with start pulsed for a single cycle.
  task automatic run(input string name, input int nn, input int kk, input int mm,
                     input bit trans, input int rmode, input bit scramble);
    ready_mode = rmode;
    load(nn, kk, mm, trans);
    expect_run(nn, kk, mm);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({name, "_busy"}, 64'(busy), 64'd1);
    if (scramble) begin
      mat_a = {4{$urandom()}};
      mat_b = {4{$urandom()}};
      n     = 2'($urandom);
      k     = 2'($urandom);
      m     = 2'($urandom);
      bt    = ~bt;
    end
    wait_done(name);
    tick();
    check({name, "_idle"}, {62'd0, done, busy}, 64'd0);
  endtask

  initial begin
    int base;
    int i;

    // Reset state
    rst = 1'b1;
    tick(); tick(); tick();
    check("reset_ctl", {61'd0, out_valid, busy, done}, 64'd0);
    check("reset_vec", {vec_a, vec_b}, 64'd0);
    rst = 1'b0;
    tick();

    // 2x2x2 directed
    for (int r = 0; r < MD; r++)
      for (int c = 0; c < MD; c++) begin
        ma[r][c] = 8'd0;
        mb[r][c] = 8'd0;
      end
    ma[0][0] = 8'd1; ma[0][1] = 8'd2; ma[1][0] = 8'd3; ma[1][1] = 8'd4;
    mb[0][0] = 8'd5; mb[0][1] = 8'd6; mb[1][0] = 8'd7; mb[1][1] = 8'd8;
    run("d222", 2, 2, 2, 1'b0, 0, 1'b0);
    run("d222_bt", 2, 2, 2, 1'b1, 0, 1'b0);

    // 4x4x4 with ready pattern stalls
    fill_random();
    run("d444_stall", 4, 4, 4, 1'b0, 1, 1'b0);

    // N=3, K=1, M=2 lane gating
    fill_random();
    run("d312", 3, 1, 2, 1'b0, 0, 1'b0);

    // Abort at FEED beat 2
    fill_random();
    ready_mode = 0;
    load(4, 4, 4, 1'b0);
    expect_run(4, 4, 4);
    base  = accepted;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    check("abort_beats_before", 64'(accepted - base), 64'd2);
    check("abort_beat2_data", {vec_a, vec_b}, exp_q[0]);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle", {61'd0, out_valid, busy, done}, 64'd0);
    exp_q.delete();
    for (i = 0; i < 4; i++) begin
      tick();
      check("abort_no_done", 64'(done), 64'd0);
    end

    // Reset in the middle of FLUSH
    run("pre_rst", 2, 2, 2, 1'b0, 0, 1'b0);
    fill_random();
    load(2, 2, 2, 1'b0);
    expect_run(2, 2, 2);
    base  = accepted;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (i = 0; i < 50 && (accepted - base) < 4; i++) tick();
    check("rst_reached_flush", 64'(accepted - base), 64'd4);
    rst = 1'b1;
    tick();
    check("rst_mid_ctl", {61'd0, out_valid, busy, done}, 64'd0);
    check("rst_mid_vec", {vec_a, vec_b}, 64'd0);
    rst = 1'b0;
    exp_q.delete();
    tick();

    // start held high through DONE
    fill_random();
    ready_mode = 2;
    load(3, 2, 4, 1'b0);
    expect_run(3, 2, 4);
    start = 1'b1;
    tick();
    wait_done("held");
    for (i = 0; i < 3; i++) begin
      tick();
      check("held_no_retrigger", {62'd0, out_valid, done}, 64'd1);
    end
    start = 1'b0;
    tick();
    check("held_release", 64'(done), 64'd0);
    fill_random();
    run("rerun", 2, 3, 1, 1'b0, 0, 1'b0);

    // Randomized runs with inputs scrambled after start
    for (int r = 0; r < 12; r++) begin
      fill_random();
      run("rand", int'($urandom_range(1, 4)), int'($urandom_range(1, 4)),
          int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)),
          int'($urandom_range(0, 2)), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
